// File: rtl/irq_grant_controller.sv
// ==========================================================================
// irq_grant_controller: 8-line IRQ sync/latch, mask, fixed-priority grant
// with req/ack/EOI handshake and a registered one-hot grant.  Rev 1.0
// ==========================================================================
`default_nettype none

module irq_grant_controller #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic [7:0] irq_mask,
  output logic [7:0] pending,
  output logic [7:0] in_service,
  output logic       int_req,
  input  logic       int_ack,
  input  logic       eoi,
  output logic [7:0] grant_onehot,
  output logic       grant_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0]   sync_q, sync_d;
  logic [7:0]                    sync_dly_q, sync_dly_d;
  logic [7:0]                    pending_q, pending_d;
  logic [7:0]                    mask_q, mask_d;
  logic [7:0]                    in_service_q, in_service_d;
  logic [7:0]                    grant_q, grant_d;
  logic                          int_req_q, int_req_d;

  logic [7:0] sync;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] eligible;
  logic [7:0] lowest;

  assign sync = sync_q[SYNC_STAGES-1];

  // Datapath: synchroniser, request latching and masking
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq_in};
    sync_dly_d = sync;
    set_vec    = EDGE_MODE ? (sync & ~sync_dly_q) : sync;
    clr_vec    = (state_q == S_REQ && int_ack) ? grant_q : 8'h00;
    // A new request on the acknowledged line survives the clear.
    pending_d  = (pending_q & ~clr_vec) | set_vec;
    mask_d     = mask_wr ? mask_data : mask_q;
    eligible   = pending_q & ~mask_q;
    lowest     = eligible & (~eligible + 8'd1);
  end

  // Handshake FSM
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    unique case (state_q)
      S_IDLE: begin
        if (eligible != 8'h00) begin
          grant_d   = lowest;
          int_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          in_service_d = grant_q;
          int_req_d    = 1'b0;
          state_d      = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (eoi) begin
          in_service_d = 8'h00;
          grant_d      = 8'h00;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        grant_d      = 8'h00;
        int_req_d    = 1'b0;
        in_service_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      sync_dly_q   <= 8'h00;
      pending_q    <= 8'h00;
      mask_q       <= 8'hFF;
      in_service_q <= 8'h00;
      grant_q      <= 8'h00;
      int_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      sync_dly_q   <= sync_dly_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      grant_q      <= grant_d;
      int_req_q    <= int_req_d;
    end
  end

  assign irq_mask     = mask_q;
  assign pending      = pending_q;
  assign in_service   = in_service_q;
  assign int_req      = int_req_q;
  assign grant_onehot = grant_q;
  assign grant_valid  = |grant_q;

endmodule

`default_nettype wire

// File: doc/irq_grant_controller.md
Name: irq_grant_controller

Overview:
- 8-line interrupt request controller that feeds the 8-to-3 one-hot encoder.
- Synchronises and latches IRQ lines, applies a mask, and arbitrates by fixed priority.
- Runs a req/ack/EOI handshake with the CPU.
- Drives a registered, strictly one-hot (or all-zero) grant vector; the encoder turns it into a 3-bit vector number.

Parameters:
- SYNC_STAGES, 2, number of flops in the irq_in synchroniser chain (>=2).
- EDGE_MODE, 1, 1 = latch on rising edge of synchronised IRQ; 0 = level-sensitive.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- irq_in  input  8  raw interrupt request lines, asynchronous to clk
- mask_wr  input  1  one-cycle strobe: load mask_data into irq_mask
- mask_data  input  8  new mask value; bit=1 disables that line
- irq_mask  output  8  current mask register
- pending  output  8  latched, not-yet-acknowledged requests
- in_service  output  8  one-hot in-service bit, zero when idle
- int_req  output  1  interrupt request to CPU
- int_ack  input  1  CPU acknowledge, sampled only in REQ
- eoi  input  1  CPU end-of-interrupt, sampled only in SERVICE
- grant_onehot  output  8  granted line, one-hot or 8'h00; feeds the encoder input
- grant_valid  output  1  high whenever grant_onehot is non-zero

Behaviour:
- Reset (async, rst=1): synchroniser flops, edge history, pending, in_service, grant_onehot = 0; int_req = 0; grant_valid = 0; irq_mask = 8'hFF (all masked); FSM = IDLE. Reset mid-transaction discards all pending and in-service state.
- Synchroniser: SYNC_STAGES flops per bit. sync = last stage; sync_d = sync delayed one cycle.
- EDGE_MODE=1: pending[i] is set on a cycle where sync[i]=1 and sync_d[i]=0.
- EDGE_MODE=0: pending[i] is set on any cycle where sync[i]=1.
- pending[i] is cleared only by int_ack for the granted line. If set and clear occur in the same cycle, set wins.
- Masked bits still latch into pending but are not eligible. eligible = pending & ~irq_mask (registered mask; a mask_wr takes effect the next cycle).
- Priority: fixed, bit 0 highest, bit 7 lowest.
- FSM IDLE: if eligible != 0, register grant_onehot = lowest set bit of eligible, set int_req=1 and grant_valid=1, go to REQ. Otherwise stay.
- FSM REQ: grant_onehot is held stable; it is not re-arbitrated even if a higher-priority request arrives or the mask changes. On int_ack=1:
  - clear pending[g], set in_service[g];
  - int_req goes 0 on the same edge;
  - go to SERVICE.
- FSM SERVICE: grant_onehot and grant_valid are held. On eoi=1: clear in_service, grant_onehot=0, grant_valid=0, go to IDLE.
- After EOI, IDLE re-arbitrates on the next cycle, so there is at least one cycle with grant_valid=0 between grants.
- No nesting: at most one line is in service.
- int_ack outside REQ and eoi outside SERVICE are ignored with no state change.
- Latency (SYNC_STAGES=2, EDGE_MODE=1, unmasked, IDLE): if irq_in[i] rises before clk edge k:
  - sync high after edge k+1;
  - pending[i] high after edge k+2;
  - int_req high after edge k+3.
- Invariant: grant_onehot is always 8'h00 or exactly one bit set, never a multi-bit pattern.
- Invariant: in_service == grant_onehot while in SERVICE.

Test Plan:
- Reset then mask_wr with 8'h00; pulse irq_in[5] -> int_req=1 and grant_onehot=8'h20 after the 4th clk edge; int_ack -> pending[5]=0, in_service=8'h20; eoi -> grant_onehot=8'h00, FSM back to IDLE.
- irq_in[3] and irq_in[6] rise in the same cycle -> grant 8'h08 first. After ack and eoi -> grant 8'h40 on the following arbitration with no lost request.
- Mask 8'h04; pulse irq_in[2] -> pending=8'h04, int_req stays 0. Write mask 8'h00 -> int_req=1, grant 8'h04 the cycle after the mask takes effect.
- While in REQ with grant 8'h80, pulse irq_in[0] -> grant stays 8'h80 until eoi. Then grant 8'h01 is issued.
- In REQ, new edge on the granted line coincident with int_ack -> pending bit stays 1 and is re-granted after eoi. Spurious eoi in IDLE and int_ack in SERVICE -> no state change.
- Assert rst during SERVICE -> all outputs immediately 0 except irq_mask=8'hFF. EDGE_MODE=0 build: a held irq_in[1] re-requests after each eoi.
